mips_multicycle_control: RTL and testbench

Parametrised multicycle control unit for the MIPS core: a Moore-style FSM that sequences fetch, decode, execute, memory and write-back over several cycles and drives the shared-datapath mux/enable signals. It adds a memory ready handshake with timeout, an illegal-opcode trap, and saturating retire and cycle counters. It sits between the instruction register's opcode field and the multicycle datapath, replacing the single-cycle decoder.

---
 rtl/mips_multicycle_control_if.sv | 42 ++++
 rtl/mips_multicycle_control.sv | 243 ++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_control_if.sv
// Bundle between the multicycle control FSM and the shared datapath / memory.
// The controller owns the master modport; the datapath side uses slave.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
) ();
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;

  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             MemToReg;
  logic             IRWrite;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;

  logic             retired;
  logic             trap;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           retired, trap, cycle_count, instr_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           retired, trap, cycle_count, instr_count
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready timeout, illegal-opcode trap and
// saturating counters. Define MIPS_MC_ADDI_EN to add the addi execute/write-back path.
module mips_multicycle_control #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  mips_multicycle_control_if.master bus
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MIPS_MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXECUTE,
    S_R_WB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
`ifdef MIPS_MC_ADDI_EN
    ,
    S_ADDI_EXEC,
    S_ADDI_WB
`endif
  } state_e;

  // Moore controls; IRWrite and the FETCH part of PCWrite depend on mem_ready
  // and are combined at the output instead.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic ctl_t state_ctl(state_e s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_R_WB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB:   c.reg_write = 1'b1;
`endif
      default:     c = '0;
    endcase
    return c;
  endfunction

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [5:0]        op_q, op_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  ctl_t              ctl_q;
  logic              retired_q, trap_q;
  logic              retire_d, mem_wait;

  // The ALU zero flag is gated with PCWriteCond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = bus.zero;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and infers a latch.
    state_d  = state_q;
    op_d     = op_q;
    retire_d = 1'b0;
    mem_wait = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               mem_wait = 1'b1;
      end
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: begin
        if (bus.mem_ready) state_d = S_MEM_WB;
        else               mem_wait = 1'b1;
      end
      S_MEM_WB: begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        if (bus.mem_ready) begin
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else begin
          mem_wait = 1'b1;
        end
      end
      S_EXECUTE: state_d = S_R_WB;
      S_R_WB, S_BRANCH, S_JUMP: begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB: begin
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // wait_q counts earlier stalled cycles, so this is the TIMEOUT-th one.
    if (mem_wait && (wait_q == WAIT_W'(TIMEOUT - 1))) state_d = S_TRAP;

    if (state_d != state_q) wait_d = '0;
    else if (mem_wait)      wait_d = wait_q + 1'b1;
    else                    wait_d = wait_q;

    cycle_d = cycle_q;
    if ((state_q != S_TRAP) && (cycle_q != '1)) cycle_d = cycle_q + 1'b1;

    instr_d = instr_q;
    if (retire_d && (instr_q != '1)) instr_d = instr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, and every register here has an async reset value.
    if (!reset_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      op_q      <= '0;
      cycle_q   <= '0;
      instr_q   <= '0;
      ctl_q     <= state_ctl(S_FETCH);
      retired_q <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      ctl_q     <= state_ctl(state_d);
      retired_q <= retire_d;
      trap_q    <= (state_d == S_TRAP);
    end
  end

  logic fetch_ready;
  assign fetch_ready = (state_q == S_FETCH) && bus.mem_ready;

  assign bus.PCWrite     = ctl_q.pc_write | fetch_ready;
  assign bus.IRWrite     = fetch_ready;
  assign bus.PCWriteCond = ctl_q.pc_write_cond;
  assign bus.IorD        = ctl_q.i_or_d;
  assign bus.MemRead     = ctl_q.mem_read;
  assign bus.MemWrite    = ctl_q.mem_write;
  assign bus.MemToReg    = ctl_q.mem_to_reg;
  assign bus.RegDst      = ctl_q.reg_dst;
  assign bus.RegWrite    = ctl_q.reg_write;
  assign bus.ALUSrcA     = ctl_q.alu_src_a;
  assign bus.ALUSrcB     = ctl_q.alu_src_b;
  assign bus.ALUOp       = ctl_q.alu_op;
  assign bus.PCSource    = ctl_q.pc_source;
  assign bus.retired     = retired_q;
  assign bus.trap        = trap_q;
  assign bus.cycle_count = cycle_q;
  assign bus.instr_count = instr_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomised bench for mips_multicycle_control: a per-instruction trace model
// predicts controls, trap, retire pulses and counters for two counter widths.
module tb_mips_multicycle_control;

  localparam int TO   = 4;
  localparam int CW_S = 4;
  localparam int CW_W = 16;

  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef enum {
    P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_READ, P_MEM_WB, P_MEM_WRITE,
    P_EXECUTE, P_R_WB, P_BRANCH, P_JUMP, P_ADDI_EXEC, P_ADDI_WB, P_TRAP
  } phase_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       zero;

  always #5 clk = ~clk;

  mips_multicycle_control_if #(.CNT_W(CW_S)) bus_s ();
  mips_multicycle_control_if #(.CNT_W(CW_W)) bus_w ();

  assign bus_s.opcode    = opcode;
  assign bus_s.mem_ready = mem_ready;
  assign bus_s.zero      = zero;
  assign bus_w.opcode    = opcode;
  assign bus_w.mem_ready = mem_ready;
  assign bus_w.zero      = zero;

  mips_multicycle_control #(.CNT_W(CW_S), .TIMEOUT(TO)) dut_s (
    .clk(clk), .reset_n(reset_n), .bus(bus_s)
  );
  mips_multicycle_control #(.CNT_W(CW_W), .TIMEOUT(TO)) dut_w (
    .clk(clk), .reset_n(reset_n), .bus(bus_w)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: counts since reset and whether the last cycle retired.
  int m_cycles = 0;
  int m_instr  = 0;
  bit m_ret    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic ctl_t exp_ctl(input phase_e ph, input logic rdy);
    ctl_t c;
    c = '0;
    case (ph)
      P_FETCH:     begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      P_DECODE:    c.alu_src_b = 2'b11;
      P_MEM_ADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      P_MEM_READ:  begin c.mem_read = 1; c.i_or_d = 1; end
      P_MEM_WB:    begin c.mem_to_reg = 1; c.reg_write = 1; end
      P_MEM_WRITE: begin c.mem_write = 1; c.i_or_d = 1; end
      P_EXECUTE:   begin c.alu_src_a = 1; c.alu_src_b = 2'b00; c.alu_op = 2'b10; end
      P_R_WB:      begin c.reg_dst = 1; c.reg_write = 1; end
      P_BRANCH:    begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
      P_JUMP:      begin c.pc_write = 1; c.pc_source = 2'b10; end
      P_ADDI_EXEC: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      P_ADDI_WB:   c.reg_write = 1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t act_s();
    return {bus_s.PCWrite, bus_s.PCWriteCond, bus_s.IorD, bus_s.MemRead, bus_s.MemWrite,
            bus_s.MemToReg, bus_s.IRWrite, bus_s.RegDst, bus_s.RegWrite, bus_s.ALUSrcA,
            bus_s.ALUSrcB, bus_s.ALUOp, bus_s.PCSource};
  endfunction

  function automatic ctl_t act_w();
    return {bus_w.PCWrite, bus_w.PCWriteCond, bus_w.IorD, bus_w.MemRead, bus_w.MemWrite,
            bus_w.MemToReg, bus_w.IRWrite, bus_w.RegDst, bus_w.RegWrite, bus_w.ALUSrcA,
            bus_w.ALUSrcB, bus_w.ALUOp, bus_w.PCSource};
  endfunction

  task automatic check_outputs(input string tag, input phase_e ph, input logic rdy);
    check({tag, " ctl_s"},   32'(act_s()), 32'(exp_ctl(ph, rdy)));
    check({tag, " ctl_w"},   32'(act_w()), 32'(exp_ctl(ph, rdy)));
    check({tag, " trap"},    32'({bus_s.trap, bus_w.trap}), (ph == P_TRAP) ? 32'd3 : 32'd0);
    check({tag, " retired"}, 32'({bus_s.retired, bus_w.retired}), m_ret ? 32'd3 : 32'd0);
    check({tag, " cyc_s"},   32'(bus_s.cycle_count), 32'(sat(m_cycles, CW_S)));
    check({tag, " cyc_w"},   32'(bus_w.cycle_count), 32'(sat(m_cycles, CW_W)));
    check({tag, " ins_s"},   32'(bus_s.instr_count), 32'(sat(m_instr, CW_S)));
    check({tag, " ins_w"},   32'(bus_w.instr_count), 32'(sat(m_instr, CW_W)));
  endtask

  // One clock of the trace: drive at the falling edge, check 1 time unit later.
  task automatic cycle(input phase_e ph, input logic rdy, input logic [5:0] op, input bit retires);
    opcode    = op;
    mem_ready = rdy;
    zero      = 1'($urandom);
    #1;
    check_outputs(ph.name(), ph, rdy);
    if (ph != P_TRAP) m_cycles++;
    m_ret = retires;
    if (retires) m_instr++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    mem_ready = 1'($urandom);
    opcode    = 6'($urandom);
    reset_n   = 1'b0;
    m_cycles  = 0;
    m_instr   = 0;
    m_ret     = 1'b0;
    #2;
    check_outputs("reset", P_FETCH, mem_ready);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Memory-style phase: `waits` stalled cycles, then ready; TO stalls trap.
  task automatic mem_phase(input phase_e ph, input int waits, output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < TO; i++) begin
      logic rdy;
      rdy = (i >= waits);
      cycle(ph, rdy, 6'($urandom), (ph == P_MEM_WRITE) && rdy);
      if (rdy) return;
    end
    trapped = 1'b1;
  endtask

  task automatic trap_phase();
    repeat (3) cycle(P_TRAP, 1'($urandom), 6'($urandom), 1'b0);
    do_reset();
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit t;
    mem_phase(P_FETCH, fw, t);
    if (t) begin
      trap_phase();
      return;
    end
    cycle(P_DECODE, 1'($urandom), op, 1'b0);
    case (op)
      OP_LW: begin
        cycle(P_MEM_ADDR, 1'($urandom), 6'($urandom), 1'b0);
        mem_phase(P_MEM_READ, mw, t);
        if (t) trap_phase();
        else   cycle(P_MEM_WB, 1'($urandom), 6'($urandom), 1'b1);
      end
      OP_SW: begin
        cycle(P_MEM_ADDR, 1'($urandom), 6'($urandom), 1'b0);
        mem_phase(P_MEM_WRITE, mw, t);
        if (t) trap_phase();
      end
      OP_RT: begin
        cycle(P_EXECUTE, 1'($urandom), 6'($urandom), 1'b0);
        cycle(P_R_WB, 1'($urandom), 6'($urandom), 1'b1);
      end
      OP_BEQ: cycle(P_BRANCH, 1'($urandom), 6'($urandom), 1'b1);
      OP_J:   cycle(P_JUMP, 1'($urandom), 6'($urandom), 1'b1);
`ifdef MIPS_MC_ADDI_EN
      OP_ADDI: begin
        cycle(P_ADDI_EXEC, 1'($urandom), 6'($urandom), 1'b0);
        cycle(P_ADDI_WB, 1'($urandom), 6'($urandom), 1'b1);
      end
`endif
      default: trap_phase();
    endcase
  endtask

  logic [5:0] op_pool [7];

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    opcode    = '0;
    zero      = 1'b0;
    op_pool   = '{OP_LW, OP_SW, OP_RT, OP_BEQ, OP_J, OP_ADDI, OP_BAD};
    @(negedge clk);
    do_reset();

    // Directed scenarios.
    run_instr(OP_RT, 0, 0);
    run_instr(OP_LW, 0, 3);
    run_instr(OP_SW, 1, 2);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_BAD, 0, 0);
    run_instr(OP_RT, TO, 0);
    run_instr(OP_RT, TO - 1, 0);
    run_instr(OP_LW, 0, TO);
    run_instr(OP_SW, 0, TO);
    run_instr(OP_ADDI, 0, 0);

    // Reset in the middle of a load: nothing retires or counts.
    cycle(P_FETCH, 1'b1, 6'($urandom), 1'b0);
    cycle(P_DECODE, 1'b0, OP_LW, 1'b0);
    cycle(P_MEM_ADDR, 1'b0, 6'($urandom), 1'b0);
    do_reset();

    // Retire counter saturation on the narrow instance.
    repeat (20) run_instr(OP_RT, 0, 0);
    check("instr_sat_s", 32'(bus_s.instr_count), 32'd15);
    check("instr_cnt_w", 32'(bus_w.instr_count), 32'd20);

    // Randomised instruction stream.
    repeat (250) begin
      logic [5:0] op;
      int fw, mw;
      op = op_pool[$urandom_range(0, 6)];
      if (op == OP_BAD) op = 6'($urandom);
      fw = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 3));
      run_instr(op, fw, mw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
